pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Next generation of the multicycle CPU's PC source selection: a parametrised N-way PC source mux fused with the PC register, the conditional-branch write gate, the EPC register and a two-state exception tracker.
- Sits between the control FSM / ALU datapath and instruction fetch.
- Replaces the standalone 4:1 PC mux plus the separate PC and EPC registers.
- Adds behaviour the old mux lacked:
  - registered PC;
  - beq/bne write gating;
  - misaligned-target fault;
  - exception entry to a fixed vector;
  - return from exception (eret) through the internal EPC;
  - nested-exception blocking.

Parameters:
- WIDTH, 32: PC / data width in bits; must be >= 8.
- NSRC, 4: number of external PC sources; must be >= 2.
- SELW, $clog2(NSRC): width of pc_src.
- RESET_VECTOR, 32'h0000_0000: PC value on reset.
- EXC_VECTOR, 32'h0000_00FC: PC value loaded on exception entry.
- ALIGN_BITS, 2: low bits of a target that must be zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_src  in  SELW  selects the external source.
- src_data  in  NSRC*WIDTH  flattened sources; source i is at bits [i*WIDTH +: WIDTH].
- pc_write  in  1  unconditional PC write.
- pc_write_cond  in  1  conditional (branch) PC write.
- branch_ne  in  1  condition select: 0 = write when zero=1 (beq); 1 = write when zero=0 (bne).
- zero  in  1  ALU zero flag.
- exc_req  in  1  exception request; level, sampled on each edge.
- eret  in  1  return from exception.
- pc  out  WIDTH  current PC.
- epc  out  WIDTH  saved exception PC.
- in_exc  out  1  1 while in state EXC.
- addr_fault  out  1  one-cycle pulse: misaligned target rejected.
- exc_dropped  out  1  one-cycle pulse: exc_req or fault ignored while in EXC.
- eret_illegal  out  1  one-cycle pulse: eret ignored while in RUN.

Behaviour:
- **Reset (asynchronous, immediate)**
  - pc = RESET_VECTOR, epc = 0, state = RUN, in_exc = 0.
  - addr_fault, exc_dropped, eret_illegal = 0.
  - Reset asserted mid-cycle aborts any pending write.
- **Source selection (combinational)**
  - sel = src_data[pc_src]. A pc_src value >= NSRC selects source 0.
  - target = sel.
  - misaligned = (target[ALIGN_BITS-1:0] != 0). With ALIGN_BITS = 0, misaligned is always 0.
- **Write gate**
  - take = pc_write | (pc_write_cond & (zero ^ branch_ne)).
- **State RUN, priority per edge (highest first)**
  1. exc_req: epc <= pc; pc <= EXC_VECTOR; state -> EXC.
  2. take & misaligned: pc unchanged; addr_fault pulses; epc <= pc; pc <= EXC_VECTOR; state -> EXC. A simultaneous exc_req wins, and addr_fault still pulses.
  3. eret: ignored; eret_illegal pulses.
  4. take: pc <= target.
  5. Otherwise: hold.
- **State EXC, priority per edge (highest first)**
  1. eret: pc <= epc; state -> RUN. The same-cycle exc_req or take is ignored, and exc_dropped pulses if exc_req = 1.
  2. exc_req: ignored; epc unchanged; exc_dropped pulses. Any simultaneous take still proceeds per items 3 and 4.
  3. take & misaligned: pc unchanged; addr_fault and exc_dropped both pulse.
  4. take: pc <= target; handler code runs normally.
- **Timing and widths**
  - All pulse outputs are registered: high exactly in the cycle after the triggering edge, then 0.
  - Latency: a write is visible on pc one cycle after the edge where take = 1.
  - No arithmetic: PC increment comes from the ALU via a source.
  - Every register is WIDTH bits; EXC_VECTOR and RESET_VECTOR are truncated to WIDTH.

Decomposition:
- Shared package pc_pkg holds:
  - state enum {RUN, EXC};
  - default vector constants;
  - source index constants PCSRC_ALU = 0, PCSRC_ALUOUT = 1, PCSRC_JUMP = 2.
- One natural sub-module, pc_src_mux: parametrised NSRC:1 combinational mux with out-of-range fallback.
- The registers and FSM stay in pc_next_unit.

Test Plan:
- Reset / unconditional write:
  - Assert reset mid-cycle with pc = 0x40 -> pc = 0 immediately.
  - Release; pc_src = 0, src0 = 0x4, pc_write = 1 -> pc = 0x4 the next cycle.
- Branch gating:
  - pc_write_cond = 1, branch_ne = 0, zero = 1, src1 = 0x100 -> pc = 0x100.
  - Same inputs with zero = 0 -> pc holds.
  - branch_ne = 1, zero = 0 -> pc = 0x100.
- Misaligned target:
  - pc = 0x20, src2 = 0x102, pc_src = 2, pc_write = 1 -> addr_fault pulses once, epc = 0x20, pc = 0xFC, in_exc = 1.
- Exception, handler step, return:
  - pc = 0x30, exc_req = 1 -> epc = 0x30, pc = 0xFC.
  - Handler write to 0x200 -> pc = 0x200.
  - eret -> pc = 0x30, in_exc = 0.
- Nested and illegal:
  - In EXC, exc_req = 1 -> exc_dropped pulses, epc unchanged.
  - In RUN, eret = 1 -> eret_illegal pulses, pc holds.
- Parameter sweep: NSRC = 3, WIDTH = 16.
  - pc_src = 3 with src0 = 0x8 and pc_write = 1 -> pc = 0x8.
  - Repeat exception entry -> pc = 0x00FC.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC next-value unit: FSM states,
// default vectors and the canonical PC source indices.
package pc_pkg;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_EXC = 1'b1
   } pc_state_e;

   localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_00FC;

   localparam int PCSRC_ALU    = 0;
   localparam int PCSRC_ALUOUT = 1;
   localparam int PCSRC_JUMP   = 2;

endpackage

// File: rtl/pc_src_mux.sv
// NSRC:1 combinational PC source mux over a flattened source bus.
// Select values with no matching source fall back to source 0.
module pc_src_mux
   import pc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NSRC  = 4,
   parameter int SELW  = $clog2(NSRC)
) (
   input  logic [SELW-1:0]       sel_i,
   input  logic [NSRC*WIDTH-1:0] data_i,
   output logic [WIDTH-1:0]      data_o
);

   always_comb begin
      data_o = data_i[WIDTH-1:0];
      for (int i = 1; i < NSRC; i++) begin
         if (sel_i == SELW'(i)) data_o = data_i[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/pc_next_unit.sv
// Registered PC with source select, branch write gate, EPC and a RUN/EXC
// exception tracker with misaligned-target fault and eret support.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | normal execution; exc_req or a misaligned write enters EXC
// ST_EXC  | handler running; nested requests dropped, eret returns to EPC
module pc_next_unit
   import pc_pkg::*;
#(
   parameter int          WIDTH        = 32,
   parameter int          NSRC         = 4,
   parameter int          SELW         = $clog2(NSRC),
   parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = PC_EXC_VECTOR,
   parameter int          ALIGN_BITS   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SELW-1:0]       pc_src,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic                  pc_write,
   input  logic                  pc_write_cond,
   input  logic                  branch_ne,
   input  logic                  zero,
   input  logic                  exc_req,
   input  logic                  eret,
   output logic [WIDTH-1:0]      pc,
   output logic [WIDTH-1:0]      epc,
   output logic                  in_exc,
   output logic                  addr_fault,
   output logic                  exc_dropped,
   output logic                  eret_illegal
);

   localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VECTOR);
   localparam logic [WIDTH-1:0] EXC_V = WIDTH'(EXC_VECTOR);

   logic [WIDTH-1:0] target;
   logic             misaligned;
   logic             take;
   logic             bad_take;

   pc_state_e        state_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] epc_q;
   logic             addr_fault_q;
   logic             exc_dropped_q;
   logic             eret_illegal_q;

   pc_src_mux #(
      .WIDTH (WIDTH),
      .NSRC  (NSRC),
      .SELW  (SELW)
   ) u_mux (
      .sel_i  (pc_src),
      .data_i (src_data),
      .data_o (target)
   );

   if (ALIGN_BITS > 0) begin : g_align
      assign misaligned = |target[ALIGN_BITS-1:0];
   end else begin : g_noalign
      assign misaligned = 1'b0;
   end

   assign take     = pc_write | (pc_write_cond & (zero ^ branch_ne));
   assign bad_take = take & misaligned;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_RUN;
         pc_q           <= RST_V;
         epc_q          <= '0;
         addr_fault_q   <= 1'b0;
         exc_dropped_q  <= 1'b0;
         eret_illegal_q <= 1'b0;
      end else begin
         addr_fault_q   <= 1'b0;
         exc_dropped_q  <= 1'b0;
         eret_illegal_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               // A rejected write still reports its fault even when exc_req wins.
               if (exc_req || bad_take) begin
                  addr_fault_q <= bad_take;
                  epc_q        <= pc_q;
                  pc_q         <= EXC_V;
                  state_q      <= ST_EXC;
               end else if (eret) begin
                  eret_illegal_q <= 1'b1;
               end else if (take) begin
                  pc_q <= target;
               end
            end
            ST_EXC: begin
               if (eret) begin
                  pc_q          <= epc_q;
                  state_q       <= ST_RUN;
                  exc_dropped_q <= exc_req;
               end else if (bad_take) begin
                  addr_fault_q  <= 1'b1;
                  exc_dropped_q <= 1'b1;
               end else begin
                  exc_dropped_q <= exc_req;
                  if (take) pc_q <= target;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign pc           = pc_q;
   assign epc          = epc_q;
   assign in_exc       = (state_q == ST_EXC);
   assign addr_fault   = addr_fault_q;
   assign exc_dropped  = exc_dropped_q;
   assign eret_illegal = eret_illegal_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios, a randomized run
// against a behavioural model, and a NSRC=3 / WIDTH=16 instance.
module tb_pc_next_unit;
   import pc_pkg::*;

   logic clk;
   logic reset;

   logic [1:0]   pc_src;
   logic [31:0]  src [4];
   logic [127:0] src_data;
   logic pc_write, pc_write_cond, branch_ne, zero, exc_req, eret;
   logic [31:0]  pc, epc;
   logic in_exc, addr_fault, exc_dropped, eret_illegal;

   logic [1:0]  b_pc_src;
   logic [15:0] b_src [3];
   logic [47:0] b_src_data;
   logic b_pc_write, b_pc_write_cond, b_branch_ne, b_zero, b_exc_req, b_eret;
   logic [15:0] b_pc, b_epc;
   logic b_in_exc, b_addr_fault, b_exc_dropped, b_eret_illegal;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model of DUT A
   logic [31:0] m_pc, m_epc;
   bit m_exc, m_fault, m_drop, m_ill;

   assign src_data   = {src[3], src[2], src[1], src[0]};
   assign b_src_data = {b_src[2], b_src[1], b_src[0]};

   pc_next_unit dut (
      .clk (clk), .reset (reset), .pc_src (pc_src), .src_data (src_data),
      .pc_write (pc_write), .pc_write_cond (pc_write_cond), .branch_ne (branch_ne),
      .zero (zero), .exc_req (exc_req), .eret (eret), .pc (pc), .epc (epc),
      .in_exc (in_exc), .addr_fault (addr_fault), .exc_dropped (exc_dropped),
      .eret_illegal (eret_illegal)
   );

   pc_next_unit #(.WIDTH (16), .NSRC (3)) dut_b (
      .clk (clk), .reset (reset), .pc_src (b_pc_src), .src_data (b_src_data),
      .pc_write (b_pc_write), .pc_write_cond (b_pc_write_cond), .branch_ne (b_branch_ne),
      .zero (b_zero), .exc_req (b_exc_req), .eret (b_eret), .pc (b_pc), .epc (b_epc),
      .in_exc (b_in_exc), .addr_fault (b_addr_fault), .exc_dropped (b_exc_dropped),
      .eret_illegal (b_eret_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      pc_src = 2'd0; pc_write = 0; pc_write_cond = 0; branch_ne = 0;
      zero = 0; exc_req = 0; eret = 0;
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_epc = 32'h0; m_exc = 0; m_fault = 0; m_drop = 0; m_ill = 0;
   endtask

   // Computes the model's next state from the spec rules, then advances one edge.
   task automatic tick();
      logic [31:0] tgt;
      logic [31:0] n_pc, n_epc;
      bit take, mis, n_exc, f, d, il;
      tgt   = src[int'(pc_src)];
      take  = pc_write || (pc_write_cond && (branch_ne ? !zero : zero));
      mis   = (tgt % 4) != 0;
      n_pc  = m_pc; n_epc = m_epc; n_exc = m_exc; f = 0; d = 0; il = 0;
      if (!m_exc) begin
         if (exc_req || (take && mis)) begin
            f = take && mis; n_epc = m_pc; n_pc = 32'hFC; n_exc = 1;
         end else if (eret) il = 1;
         else if (take) n_pc = tgt;
      end else begin
         if (eret) begin
            n_pc = m_epc; n_exc = 0; d = exc_req;
         end else begin
            d = exc_req;
            if (take && mis) begin f = 1; d = 1; end
            else if (take) n_pc = tgt;
         end
      end
      @(posedge clk); #1;
      m_pc = n_pc; m_epc = n_epc; m_exc = n_exc; m_fault = f; m_drop = d; m_ill = il;
   endtask

   task automatic load_pc(input logic [31:0] v);
      idle(); src[0] = v; pc_src = 2'(PCSRC_ALU); pc_write = 1; tick(); idle();
   endtask

   task automatic test_reset();
      idle(); reset = 1;
      for (int i = 0; i < 4; i++) src[i] = 32'h0;
      repeat (2) @(posedge clk); #1;
      reset = 0; model_reset();
      n_tests++;
      if (pc !== 32'h0 || epc !== 32'h0 || in_exc !== 1'b0 || addr_fault !== 1'b0 ||
          exc_dropped !== 1'b0 || eret_illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: pc=%h epc=%h in_exc=%b pulses=%b%b%b, expected all zero",
                  pc, epc, in_exc, addr_fault, exc_dropped, eret_illegal);
      end
      load_pc(32'h40);
      n_tests++;
      if (pc !== 32'h40) begin n_fail++; $display("FAIL preload_40: pc=%h expected 00000040", pc); end
      src[0] = 32'h44; pc_write = 1;
      #3; reset = 1; #1;
      n_tests++;
      if (pc !== 32'h0) begin n_fail++; $display("FAIL async_reset: pc=%h expected 00000000", pc); end
      @(posedge clk); #1;
      n_tests++;
      if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_aborts_write: pc=%h expected 00000000", pc); end
      reset = 0; model_reset(); idle();
   endtask

   task automatic test_uncond_write();
      src[0] = 32'h4; pc_src = 2'(PCSRC_ALU); pc_write = 1;
      tick(); idle();
      n_tests++;
      if (pc !== 32'h4) begin n_fail++; $display("FAIL uncond_write: pc=%h expected 00000004", pc); end
   endtask

   task automatic test_branch();
      src[1] = 32'h100; pc_src = 2'(PCSRC_ALUOUT); pc_write_cond = 1; branch_ne = 0; zero = 1;
      tick(); idle();
      n_tests++;
      if (pc !== 32'h100) begin n_fail++; $display("FAIL beq_taken: pc=%h expected 00000100", pc); end
      load_pc(32'h8);
      pc_src = 2'(PCSRC_ALUOUT); pc_write_cond = 1; branch_ne = 0; zero = 0;
      tick(); idle();
      n_tests++;
      if (pc !== 32'h8) begin n_fail++; $display("FAIL beq_not_taken: pc=%h expected 00000008", pc); end
      pc_src = 2'(PCSRC_ALUOUT); pc_write_cond = 1; branch_ne = 1; zero = 1;
      tick(); idle();
      n_tests++;
      if (pc !== 32'h8) begin n_fail++; $display("FAIL bne_not_taken: pc=%h expected 00000008", pc); end
      pc_src = 2'(PCSRC_ALUOUT); pc_write_cond = 1; branch_ne = 1; zero = 0;
      tick(); idle();
      n_tests++;
      if (pc !== 32'h100) begin n_fail++; $display("FAIL bne_taken: pc=%h expected 00000100", pc); end
   endtask

   task automatic test_misaligned();
      load_pc(32'h20);
      src[2] = 32'h102; pc_src = 2'(PCSRC_JUMP); pc_write = 1;
      tick(); idle();
      n_tests++;
      if (addr_fault !== 1'b1 || epc !== 32'h20 || pc !== 32'hFC || in_exc !== 1'b1) begin
         n_fail++;
         $display("FAIL misaligned_entry: fault=%b epc=%h pc=%h in_exc=%b expected 1/00000020/000000fc/1",
                  addr_fault, epc, pc, in_exc);
      end
      tick();
      n_tests++;
      if (addr_fault !== 1'b0) begin n_fail++; $display("FAIL fault_one_pulse: addr_fault=%b expected 0", addr_fault); end
      eret = 1; tick(); idle();
      n_tests++;
      if (pc !== 32'h20 || in_exc !== 1'b0) begin
         n_fail++; $display("FAIL fault_return: pc=%h in_exc=%b expected 00000020/0", pc, in_exc);
      end
   endtask

   task automatic test_exception();
      load_pc(32'h30);
      exc_req = 1; tick(); idle();
      n_tests++;
      if (epc !== 32'h30 || pc !== 32'hFC || in_exc !== 1'b1) begin
         n_fail++; $display("FAIL exc_entry: epc=%h pc=%h in_exc=%b expected 00000030/000000fc/1", epc, pc, in_exc);
      end
      src[1] = 32'h200; pc_src = 2'(PCSRC_ALUOUT); pc_write = 1; tick(); idle();
      n_tests++;
      if (pc !== 32'h200 || in_exc !== 1'b1) begin
         n_fail++; $display("FAIL handler_write: pc=%h in_exc=%b expected 00000200/1", pc, in_exc);
      end
      eret = 1; tick(); idle();
      n_tests++;
      if (pc !== 32'h30 || in_exc !== 1'b0) begin
         n_fail++; $display("FAIL eret_return: pc=%h in_exc=%b expected 00000030/0", pc, in_exc);
      end
   endtask

   task automatic test_nested_illegal();
      exc_req = 1; tick();
      tick(); idle();
      n_tests++;
      if (exc_dropped !== 1'b1 || epc !== 32'h30 || pc !== 32'hFC) begin
         n_fail++; $display("FAIL nested_drop: dropped=%b epc=%h pc=%h expected 1/00000030/000000fc",
                             exc_dropped, epc, pc);
      end
      tick();
      n_tests++;
      if (exc_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_one_pulse: exc_dropped=%b expected 0", exc_dropped); end
      eret = 1; tick();
      tick(); idle();
      n_tests++;
      if (eret_illegal !== 1'b1 || pc !== 32'h30 || in_exc !== 1'b0) begin
         n_fail++; $display("FAIL eret_illegal: flag=%b pc=%h in_exc=%b expected 1/00000030/0",
                             eret_illegal, pc, in_exc);
      end
      tick();
      n_tests++;
      if (eret_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_one_pulse: eret_illegal=%b expected 0", eret_illegal); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++)
            src[i] = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         pc_src        = 2'($urandom_range(0, 3));
         pc_write      = ($urandom_range(0, 3) == 0);
         pc_write_cond = ($urandom_range(0, 3) == 0);
         branch_ne     = 1'($urandom_range(0, 1));
         zero          = 1'($urandom_range(0, 1));
         exc_req       = ($urandom_range(0, 9) == 0);
         eret          = ($urandom_range(0, 6) == 0);
         tick();
         n_tests++;
         if (pc !== m_pc || epc !== m_epc || in_exc !== m_exc || addr_fault !== m_fault ||
             exc_dropped !== m_drop || eret_illegal !== m_ill) begin
            n_fail++;
            $display("FAIL random[%0d]: pc=%h/%h epc=%h/%h exc=%b/%b fault=%b/%b drop=%b/%b ill=%b/%b (got/expected)",
                     c, pc, m_pc, epc, m_epc, in_exc, m_exc, addr_fault, m_fault,
                     exc_dropped, m_drop, eret_illegal, m_ill);
         end
      end
      idle();
   endtask

   task automatic test_param_sweep();
      b_src[0] = 16'h0008; b_src[1] = 16'h0040; b_src[2] = 16'h0080;
      b_pc_src = 2'd3; b_pc_write = 1;
      tick(); b_pc_write = 0;
      n_tests++;
      if (b_pc !== 16'h0008) begin n_fail++; $display("FAIL sweep_out_of_range_sel: pc=%h expected 0008", b_pc); end
      b_pc_src = 2'd2; b_pc_write = 1;
      tick(); b_pc_write = 0;
      n_tests++;
      if (b_pc !== 16'h0080) begin n_fail++; $display("FAIL sweep_src2: pc=%h expected 0080", b_pc); end
      b_exc_req = 1; tick(); b_exc_req = 0;
      n_tests++;
      if (b_pc !== 16'h00FC || b_epc !== 16'h0080 || b_in_exc !== 1'b1) begin
         n_fail++; $display("FAIL sweep_exc_entry: pc=%h epc=%h in_exc=%b expected 00fc/0080/1", b_pc, b_epc, b_in_exc);
      end
   endtask

   initial begin
      b_pc_src = 2'd0; b_pc_write = 0; b_pc_write_cond = 0; b_branch_ne = 0;
      b_zero = 0; b_exc_req = 0; b_eret = 0;
      for (int i = 0; i < 3; i++) b_src[i] = 16'h0;
      test_reset();
      test_uncond_write();
      test_branch();
      test_misaligned();
      test_exception();
      test_nested_illegal();
      test_random();
      test_param_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
